mission_sequencer: RTL and testbench

Parametrised mission-level task sequencer that walks the robot through `NUM_TARGETS` inspection targets in order. For each target it runs navigate → inspect → hand-off → transmit. It sits between navigation, inspection and the UART comms path. Over the single-target task FSM it adds a target counter, a ready/valid hand-off to comms, per-phase watchdog timeouts with bounded retry, abort, a FAULT state, and worst-case health tracking across the mission.

---
 rtl/mission_sequencer.sv | 137 +++++++++++++
 tb/tb_mission_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mission_sequencer.sv
// mission_sequencer: walks NUM_TARGETS targets through navigate/inspect/hand-off/transmit.
// Define MISSION_SEQ_TIMEOUT_EN to compile in the per-phase watchdog and bounded retry.
module mission_sequencer #(
   parameter int NUM_TARGETS    = 4,
   parameter int HEALTH_W       = 2,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int MAX_RETRIES    = 2,
   localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic                target_reached,
   input  logic                inspection_complete,
   input  logic [HEALTH_W-1:0] health_status,
   input  logic                data_ready,
   input  logic                transmission_complete,
   input  logic                finished,
   output logic [2:0]          state_enc,
   output logic [IDX_W-1:0]    target_idx,
   output logic [HEALTH_W-1:0] health_out,
   output logic [HEALTH_W-1:0] health_worst,
   output logic                data_valid,
   output logic                busy,
   output logic                fault,
   output logic                done
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_NAVIGATE = 3'd1,
      S_INSPECT  = 3'd2,
      S_HANDOFF  = 3'd3,
      S_TRANSMIT = 3'd4,
      S_NEXT     = 3'd5,
      S_COMPLETE = 3'd6,
      S_FAULT    = 3'd7
   } state_t;

   state_t state, nxt;

   assign state_enc = state;

`ifdef MISSION_SEQ_TIMEOUT_EN
   localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   logic [WD_W-1:0]    wd_cnt;
   logic [RETRY_W-1:0] retry_cnt;
   logic               timed;
   logic               timeout;
   logic               retry_inc;

   assign timed   = (state == S_NAVIGATE) || (state == S_INSPECT) || (state == S_TRANSMIT);
   assign timeout = timed && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

   always_comb begin
      nxt = state;
`ifdef MISSION_SEQ_TIMEOUT_EN
      retry_inc = 1'b0;
`endif
      case (state)
         S_IDLE:     if (start)                 nxt = S_NAVIGATE;
         S_NAVIGATE: if (target_reached)        nxt = S_INSPECT;
         S_INSPECT:  if (inspection_complete)   nxt = S_HANDOFF;
         S_HANDOFF:  if (data_ready)            nxt = S_TRANSMIT;
         S_TRANSMIT: if (transmission_complete) nxt = S_NEXT;
         S_NEXT:     nxt = (target_idx == IDX_W'(NUM_TARGETS - 1)) ? S_COMPLETE : S_NAVIGATE;
         S_COMPLETE: if (finished)              nxt = S_IDLE;
         S_FAULT:    if (finished)              nxt = S_IDLE;
         default:    nxt = S_IDLE;
      endcase
`ifdef MISSION_SEQ_TIMEOUT_EN
      // A completion input in the timeout cycle has already moved nxt, so it wins.
      if (timeout && (nxt == state)) begin
         if (retry_cnt < RETRY_W'(MAX_RETRIES)) begin
            nxt       = S_NAVIGATE;
            retry_inc = 1'b1;
         end else begin
            nxt = S_FAULT;
         end
      end
`endif
      if (abort && (state != S_IDLE)) begin
         nxt = S_FAULT;
`ifdef MISSION_SEQ_TIMEOUT_EN
         retry_inc = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         target_idx   <= '0;
         health_out   <= '0;
         health_worst <= '0;
         data_valid   <= 1'b0;
         busy         <= 1'b0;
         fault        <= 1'b0;
         done         <= 1'b0;
`ifdef MISSION_SEQ_TIMEOUT_EN
         wd_cnt       <= '0;
         retry_cnt    <= '0;
`endif
      end else begin
         state      <= nxt;
         data_valid <= (nxt == S_HANDOFF);
         busy       <= !(nxt inside {S_IDLE, S_COMPLETE, S_FAULT});
         fault      <= (nxt == S_FAULT);
         done       <= (nxt == S_COMPLETE) && (state != S_COMPLETE);

         if ((state == S_IDLE) && (nxt == S_NAVIGATE)) begin
            target_idx   <= '0;
            health_out   <= '0;
            health_worst <= '0;
         end
         if ((state == S_INSPECT) && (nxt == S_HANDOFF)) begin
            health_out <= health_status;
            if (health_status > health_worst) health_worst <= health_status;
         end
         if ((state == S_NEXT) && (nxt == S_NAVIGATE)) target_idx <= target_idx + IDX_W'(1);

`ifdef MISSION_SEQ_TIMEOUT_EN
         // A retry re-enters NAVIGATE without a state change, so it restarts the count too.
         if ((nxt != state) || retry_inc) wd_cnt <= '0;
         else if (timed)                  wd_cnt <= wd_cnt + WD_W'(1);

         if (((state == S_IDLE) || (state == S_NEXT)) && (nxt == S_NAVIGATE)) retry_cnt <= '0;
         else if (retry_inc) retry_cnt <= retry_cnt + RETRY_W'(1);
`endif
      end
   end

endmodule

// File: tb/tb_mission_sequencer.sv
// Directed self-checking bench for mission_sequencer (3 targets, 20-cycle watchdog, 1 retry).
module tb_mission_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, abort, target_reached, inspection_complete;
   logic [1:0] health_status;
   logic       data_ready, transmission_complete, finished;
   logic [2:0] state_enc;
   logic [1:0] target_idx;
   logic [1:0] health_out, health_worst;
   logic       data_valid, busy, fault, done;

   int checks = 0;
   int errors = 0;

   mission_sequencer #(
      .NUM_TARGETS(3), .HEALTH_W(2), .TIMEOUT_CYCLES(20), .MAX_RETRIES(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .target_reached(target_reached), .inspection_complete(inspection_complete),
      .health_status(health_status), .data_ready(data_ready),
      .transmission_complete(transmission_complete), .finished(finished),
      .state_enc(state_enc), .target_idx(target_idx), .health_out(health_out),
      .health_worst(health_worst), .data_valid(data_valid), .busy(busy),
      .fault(fault), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL time_limit: simulation did not finish, got running expected finished");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   // From NAVIGATE up to the cycle after entering TRANSMIT.
   task automatic to_transmit(input logic [1:0] h);
      target_reached = 1'b1; tick(); target_reached = 1'b0;
      health_status = h; inspection_complete = 1'b1; tick(); inspection_complete = 1'b0;
      data_ready = 1'b1; tick(); data_ready = 1'b0;
   endtask

   task automatic run_target(input logic [1:0] h);
      to_transmit(h);
      transmission_complete = 1'b1; tick(); transmission_complete = 1'b0;
      tick();
   endtask

   task automatic cleanup();
      abort = 1'b1; tick(); abort = 1'b0;
      finished = 1'b1; tick(); finished = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      checks++; if (state_enc !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_enc); end
      checks++; if ({target_idx, health_out, health_worst} !== 6'd0) begin errors++;
         $display("FAIL reset_regs: got idx=%0d ho=%0d hw=%0d expected 0/0/0", target_idx, health_out, health_worst); end
      checks++; if ({data_valid, busy, fault, done} !== 4'b0000) begin errors++;
         $display("FAIL reset_flags: got %b expected 0000", {data_valid, busy, fault, done}); end
   endtask

   task automatic test_nominal();
      logic [1:0] h [3];
      h[0] = 2'd1; h[1] = 2'd3; h[2] = 2'd2;
      pulse_start();
      checks++; if (state_enc !== 3'd1 || busy !== 1'b1) begin errors++;
         $display("FAIL nom_start: got state=%0d busy=%b expected 1/1", state_enc, busy); end
      for (int t = 0; t < 3; t++) begin
         checks++; if (target_idx !== 2'(t)) begin errors++;
            $display("FAIL nom_idx: got %0d expected %0d", target_idx, t); end
         target_reached = 1'b1; tick(); target_reached = 1'b0;
         checks++; if (state_enc !== 3'd2) begin errors++; $display("FAIL nom_inspect: got %0d expected 2", state_enc); end
         health_status = h[t]; inspection_complete = 1'b1; tick(); inspection_complete = 1'b0;
         checks++; if (state_enc !== 3'd3 || data_valid !== 1'b1 || health_out !== h[t]) begin errors++;
            $display("FAIL nom_handoff: got state=%0d dv=%b ho=%0d expected 3/1/%0d", state_enc, data_valid, health_out, h[t]); end
         data_ready = 1'b1; tick(); data_ready = 1'b0;
         checks++; if (state_enc !== 3'd4 || data_valid !== 1'b0) begin errors++;
            $display("FAIL nom_transmit: got state=%0d dv=%b expected 4/0", state_enc, data_valid); end
         transmission_complete = 1'b1; tick(); transmission_complete = 1'b0;
         checks++; if (state_enc !== 3'd5) begin errors++; $display("FAIL nom_next: got %0d expected 5", state_enc); end
         tick();
         if (t < 2) begin
            checks++; if (state_enc !== 3'd1 || target_idx !== 2'(t + 1)) begin errors++;
               $display("FAIL nom_advance: got state=%0d idx=%0d expected 1/%0d", state_enc, target_idx, t + 1); end
         end else begin
            checks++; if (state_enc !== 3'd6 || done !== 1'b1 || busy !== 1'b0 || target_idx !== 2'd2) begin errors++;
               $display("FAIL nom_complete: got state=%0d done=%b busy=%b idx=%0d expected 6/1/0/2",
                        state_enc, done, busy, target_idx); end
         end
      end
      checks++; if (health_out !== 2'd2 || health_worst !== 2'd3) begin errors++;
         $display("FAIL nom_health: got ho=%0d hw=%0d expected 2/3", health_out, health_worst); end
      tick();
      checks++; if (state_enc !== 3'd6 || done !== 1'b0) begin errors++;
         $display("FAIL nom_done_pulse: got state=%0d done=%b expected 6/0", state_enc, done); end
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (state_enc !== 3'd6) begin errors++; $display("FAIL nom_start_ignored: got %0d expected 6", state_enc); end
      finished = 1'b1; tick(); finished = 1'b0;
      checks++; if (state_enc !== 3'd0 || busy !== 1'b0) begin errors++;
         $display("FAIL nom_finish: got state=%0d busy=%b expected 0/0", state_enc, busy); end
   endtask

   task automatic test_backpressure();
      pulse_start();
      target_reached = 1'b1; tick(); target_reached = 1'b0;
      health_status = 2'd0; inspection_complete = 1'b1; tick(); inspection_complete = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (state_enc !== 3'd3 || data_valid !== 1'b1) begin errors++;
            $display("FAIL bp_hold[%0d]: got state=%0d dv=%b expected 3/1", i, state_enc, data_valid); end
      end
      data_ready = 1'b1; tick(); data_ready = 1'b0;
      checks++; if (state_enc !== 3'd4 || data_valid !== 1'b0) begin errors++;
         $display("FAIL bp_accept: got state=%0d dv=%b expected 4/0", state_enc, data_valid); end
      abort = 1'b1; tick();
      checks++; if (state_enc !== 3'd7 || fault !== 1'b1 || busy !== 1'b0) begin errors++;
         $display("FAIL bp_abort: got state=%0d fault=%b busy=%b expected 7/1/0", state_enc, fault, busy); end
      finished = 1'b1; tick();
      checks++; if (state_enc !== 3'd7) begin errors++; $display("FAIL abort_beats_finished: got %0d expected 7", state_enc); end
      abort = 1'b0; tick(); finished = 1'b0;
      checks++; if (state_enc !== 3'd0 || fault !== 1'b0) begin errors++;
         $display("FAIL fault_exit: got state=%0d fault=%b expected 0/0", state_enc, fault); end
   endtask

   task automatic test_abort_priority();
      abort = 1'b1; tick(); abort = 1'b0;
      checks++; if (state_enc !== 3'd0) begin errors++; $display("FAIL abort_idle: got %0d expected 0", state_enc); end
      pulse_start();
      target_reached = 1'b1; tick(); target_reached = 1'b0;
      health_status = 2'd3; abort = 1'b1; inspection_complete = 1'b1; tick();
      abort = 1'b0; inspection_complete = 1'b0;
      checks++; if (state_enc !== 3'd7 || health_out !== 2'd0) begin errors++;
         $display("FAIL abort_vs_inspect: got state=%0d ho=%0d expected 7/0", state_enc, health_out); end
      finished = 1'b1; tick(); finished = 1'b0;
   endtask

`ifdef MISSION_SEQ_TIMEOUT_EN
   task automatic test_timeout_retry();
      pulse_start();
      run_target(2'd1);
      checks++; if (state_enc !== 3'd1 || target_idx !== 2'd1) begin errors++;
         $display("FAIL to_target1: got state=%0d idx=%0d expected 1/1", state_enc, target_idx); end
      for (int i = 1; i <= 19; i++) tick();
      checks++; if (state_enc !== 3'd1) begin errors++; $display("FAIL to_before_first: got %0d expected 1", state_enc); end
      tick();
      checks++; if (state_enc !== 3'd1 || target_idx !== 2'd1 || busy !== 1'b1) begin errors++;
         $display("FAIL to_retry: got state=%0d idx=%0d busy=%b expected 1/1/1", state_enc, target_idx, busy); end
      for (int i = 1; i <= 19; i++) tick();
      checks++; if (state_enc !== 3'd1) begin errors++; $display("FAIL to_before_second: got %0d expected 1", state_enc); end
      tick();
      checks++; if (state_enc !== 3'd7 || fault !== 1'b1 || busy !== 1'b0 || target_idx !== 2'd1) begin errors++;
         $display("FAIL to_fault: got state=%0d fault=%b busy=%b idx=%0d expected 7/1/0/1",
                  state_enc, fault, busy, target_idx); end
      finished = 1'b1; tick(); finished = 1'b0;
   endtask

   task automatic test_timeout_priority();
      pulse_start();
      for (int i = 1; i <= 19; i++) tick();
      target_reached = 1'b1; tick(); target_reached = 1'b0;
      checks++; if (state_enc !== 3'd2) begin errors++; $display("FAIL tp_reach_wins: got %0d expected 2", state_enc); end
      for (int i = 1; i <= 20; i++) tick();
      checks++; if (state_enc !== 3'd1) begin errors++;
         $display("FAIL tp_retry_unused: got %0d expected 1", state_enc); end
      for (int i = 1; i <= 20; i++) tick();
      checks++; if (state_enc !== 3'd7) begin errors++; $display("FAIL tp_second_fault: got %0d expected 7", state_enc); end
      finished = 1'b1; tick(); finished = 1'b0;
   endtask
`else
   task automatic test_no_timeout();
      pulse_start();
      for (int i = 0; i < 100; i++) begin
         tick();
         checks++; if (state_enc !== 3'd1 || fault !== 1'b0) begin errors++;
            $display("FAIL nt_stall[%0d]: got state=%0d fault=%b expected 1/0", i, state_enc, fault); end
      end
      cleanup();
   endtask
`endif

   task automatic test_reset_mid();
      pulse_start();
      run_target(2'd3);
      run_target(2'd2);
      to_transmit(2'd1);
      checks++; if (state_enc !== 3'd4 || target_idx !== 2'd2) begin errors++;
         $display("FAIL rm_setup: got state=%0d idx=%0d expected 4/2", state_enc, target_idx); end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if ({state_enc, target_idx, health_out, health_worst} !== 9'd0) begin errors++;
         $display("FAIL rm_regs: got state=%0d idx=%0d ho=%0d hw=%0d expected 0/0/0/0",
                  state_enc, target_idx, health_out, health_worst); end
      checks++; if ({data_valid, busy, fault, done} !== 4'b0000) begin errors++;
         $display("FAIL rm_flags: got %b expected 0000", {data_valid, busy, fault, done}); end
      pulse_start();
      checks++; if (state_enc !== 3'd1 || target_idx !== 2'd0) begin errors++;
         $display("FAIL rm_restart: got state=%0d idx=%0d expected 1/0", state_enc, target_idx); end
      run_target(2'd0);
      checks++; if (target_idx !== 2'd1 || health_worst !== 2'd0) begin errors++;
         $display("FAIL rm_fresh: got idx=%0d hw=%0d expected 1/0", target_idx, health_worst); end
      cleanup();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; target_reached = 1'b0;
      inspection_complete = 1'b0; health_status = 2'd0; data_ready = 1'b0;
      transmission_complete = 1'b0; finished = 1'b0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_abort_priority();
`ifdef MISSION_SEQ_TIMEOUT_EN
      test_timeout_retry();
      test_timeout_priority();
`else
      test_no_timeout();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
